// File: rtl/alu_decode_exec_pkg.sv
// Shared constants and helpers for the decode/ALU-control/ALU slice:
// opcode and funct encodings, 3-bit ALU operation codes, ALUOp encodings
// and the bit layout of the 9-bit control word.
package alu_decode_exec_pkg;

    // ID-stage opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // R-type funct field encodings
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // 3-bit ALU operation select; 011/100/101 are unused and give 0
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // 2-bit ALUOp carried in the control word
    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_RSVD   = 2'b11
    } alu_op_e;

    // Control word bit positions
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_ALUOP_LO = 0;

    // Assemble a control word from its named fields
    function automatic logic [8:0] make_ctrl(
        input logic       memtoreg,
        input logic       regwrite,
        input logic       branch,
        input logic       memread,
        input logic       memwrite,
        input logic       regdst,
        input logic       alusrc,
        input logic [1:0] aluop
    );
        logic [8:0] w;
        w                         = 9'b0;
        w[CTRL_MEMTOREG]          = memtoreg;
        w[CTRL_REGWRITE]          = regwrite;
        w[CTRL_BRANCH]            = branch;
        w[CTRL_MEMREAD]           = memread;
        w[CTRL_MEMWRITE]          = memwrite;
        w[CTRL_REGDST]            = regdst;
        w[CTRL_ALUSRC]            = alusrc;
        w[CTRL_ALUOP_LO +: 2]     = aluop;
        return w;
    endfunction

endpackage

// File: rtl/alu_decode_exec_alu_core.sv
// 32-bit combinational ALU datapath. A load-use stall (hazard) squashes the
// result to zero so a stalled instruction cannot produce a usable value.
module alu_decode_exec_alu_core
    import alu_decode_exec_pkg::*;
(
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic [2:0]  alu_ctrl,
    input  logic        hazard,
    output logic [31:0] result,
    output logic        zero
);

    logic [31:0] raw_s;

    // Select the ALU operation; unused codes yield zero
    always_comb begin
        raw_s = 32'd0;
        case (alu_ctrl)
            ALU_AND: raw_s = data_a & data_b;
            ALU_OR:  raw_s = data_a | data_b;
            ALU_ADD: raw_s = data_a + data_b;
            ALU_SUB: raw_s = data_a - data_b;
            ALU_SLT: raw_s = ($signed(data_a) < $signed(data_b)) ? 32'd1 : 32'd0;
            default: raw_s = 32'd0;
        endcase
    end

    // Apply the stall squash and derive the zero flag
    always_comb begin
        if (hazard) begin
            result = 32'd0;
        end else begin
            result = raw_s;
        end
        zero = (result == 32'd0);
    end

endmodule

// File: rtl/alu_decode_exec.sv
// ID-stage opcode decode, one-cycle-delayed immediate/load-store flags for
// the EX stage, ALU-control selection and the ALU datapath.
module alu_decode_exec
    import alu_decode_exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [1:0]  alu_op,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic        hazard,
    output logic [8:0]  ctrl_out,
    output logic        jmp,
    output logic        bne,
    output logic        immediate,
    output logic        andi,
    output logic        ori,
    output logic        addi,
    output logic        ls,
    output logic        ls_d,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero
);

    logic andi_d_r;
    logic ori_d_r;
    logic addi_d_r;
    logic ls_d_r;

    // Decode the ID-stage opcode into the control word and opcode flags
    always_comb begin
        ctrl_out  = 9'b0;
        jmp       = 1'b0;
        bne       = 1'b0;
        immediate = 1'b0;
        andi      = 1'b0;
        ori       = 1'b0;
        addi      = 1'b0;
        ls        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_out = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_RTYPE);
            end
            OP_LW: begin
                ctrl_out  = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_MEM);
                ls        = 1'b1;
                immediate = 1'b1;
            end
            OP_SW: begin
                ctrl_out  = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALUOP_MEM);
                ls        = 1'b1;
                immediate = 1'b1;
            end
            OP_BEQ: begin
                ctrl_out = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_BRANCH);
            end
            OP_BNE: begin
                ctrl_out = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_BRANCH);
                bne      = 1'b1;
            end
            OP_J: begin
                jmp = 1'b1;
            end
            OP_ADDI: begin
                ctrl_out  = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_MEM);
                immediate = 1'b1;
                addi      = 1'b1;
            end
            OP_ANDI: begin
                ctrl_out  = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_MEM);
                immediate = 1'b1;
                andi      = 1'b1;
            end
            OP_ORI: begin
                ctrl_out  = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_MEM);
                immediate = 1'b1;
                ori       = 1'b1;
            end
            default: begin
                ctrl_out = 9'b0;
            end
        endcase
    end

    // Carry the immediate/load-store flags into the EX stage; reset wins
    always_ff @(posedge clk) begin
        if (reset) begin
            andi_d_r <= 1'b0;
            ori_d_r  <= 1'b0;
            addi_d_r <= 1'b0;
            ls_d_r   <= 1'b0;
        end else begin
            andi_d_r <= andi;
            ori_d_r  <= ori;
            addi_d_r <= addi;
            ls_d_r   <= ls;
        end
    end

    assign ls_d = ls_d_r;

    // Pick the ALU operation: EX-stage immediate flags override ALUOp/funct
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (andi_d_r) begin
            alu_ctrl = ALU_AND;
        end else if (ori_d_r) begin
            alu_ctrl = ALU_OR;
        end else if (addi_d_r || ls_d_r) begin
            alu_ctrl = ALU_ADD;
        end else begin
            case (alu_op)
                ALUOP_MEM:    alu_ctrl = ALU_ADD;
                ALUOP_BRANCH: alu_ctrl = ALU_SUB;
                ALUOP_RSVD:   alu_ctrl = ALU_ADD;
                ALUOP_RTYPE: begin
                    case (funct)
                        FN_ADD:  alu_ctrl = ALU_ADD;
                        FN_SUB:  alu_ctrl = ALU_SUB;
                        FN_AND:  alu_ctrl = ALU_AND;
                        FN_OR:   alu_ctrl = ALU_OR;
                        FN_SLT:  alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
                default:      alu_ctrl = ALU_ADD;
            endcase
        end
    end

    alu_decode_exec_alu_core u_alu_core (
        .data_a   (data_a),
        .data_b   (data_b),
        .alu_ctrl (alu_ctrl),
        .hazard   (hazard),
        .result   (result),
        .zero     (zero)
    );

endmodule

// File: tb/tb_alu_decode_exec.sv
// Directed table-driven bench for alu_decode_exec plus hand-written
// sequences for flag latency and reset interaction.
module tb_alu_decode_exec;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        hazard;
    logic [8:0]  ctrl_out;
    logic        jmp, bne, immediate, andi, ori, addi, ls, ls_d;
    logic [2:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;

    int errors = 0;
    int checks = 0;

    alu_decode_exec dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (alu_op),
        .data_a    (data_a),
        .data_b    (data_b),
        .hazard    (hazard),
        .ctrl_out  (ctrl_out),
        .jmp       (jmp),
        .bne       (bne),
        .immediate (immediate),
        .andi      (andi),
        .ori       (ori),
        .addi      (addi),
        .ls        (ls),
        .ls_d      (ls_d),
        .alu_ctrl  (alu_ctrl),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  opcode;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic        hazard;
        logic [8:0]  ctrl;
        logic [6:0]  flags;   // {jmp,bne,immediate,andi,ori,addi,ls}
        logic        ls_d;
        logic [2:0]  alu_ctrl;
        logic [31:0] result;
        logic        zero;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(
        input logic [5:0] op, input logic [1:0] aop, input logic [5:0] fn,
        input logic [31:0] a, input logic [31:0] b, input logic hz,
        input logic [8:0] ctrl, input logic [6:0] flags, input logic lsd,
        input logic [2:0] ac, input logic [31:0] res, input logic z
    );
        vec_t v;
        v.opcode = op; v.alu_op = aop; v.funct = fn; v.a = a; v.b = b;
        v.hazard = hz; v.ctrl = ctrl; v.flags = flags; v.ls_d = lsd;
        v.alu_ctrl = ac; v.result = res; v.zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [1:0] aop, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic hz);
        opcode = op; alu_op = aop; funct = fn; data_a = a; data_b = b; hazard = hz;
    endtask

    initial begin
        // opcode, alu_op, funct, a, b, hazard | ctrl, flags, ls_d, alu_ctrl, result, zero
        vecs[0]  = mk(6'b000000, 2'b10, 6'b100000, 32'd3, 32'd4, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b010, 32'd7, 1'b0);
        vecs[1]  = mk(6'b000000, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b111, 32'd1, 1'b0);
        vecs[2]  = mk(6'b000000, 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b111, 32'd0, 1'b1);
        vecs[3]  = mk(6'b000000, 2'b10, 6'b100010, 32'd5, 32'd5, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b110, 32'd0, 1'b1);
        vecs[4]  = mk(6'b000000, 2'b10, 6'b100010, 32'd0, 32'd1, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b110, 32'hFFFFFFFF, 1'b0);
        vecs[5]  = mk(6'b000000, 2'b10, 6'b100100, 32'h0000F0F0, 32'h000000FF, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b000, 32'h000000F0, 1'b0);
        vecs[6]  = mk(6'b000000, 2'b10, 6'b100101, 32'h0000F0F0, 32'h000000FF, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b001, 32'h0000F0FF, 1'b0);
        vecs[7]  = mk(6'b000000, 2'b10, 6'b000111, 32'hFFFFFFFF, 32'd1, 1'b0,
                      9'b010001010, 7'b0000000, 1'b0, 3'b010, 32'd0, 1'b1);
        vecs[8]  = mk(6'b000100, 2'b01, 6'b000000, 32'd9, 32'd4, 1'b0,
                      9'b001000001, 7'b0000000, 1'b0, 3'b110, 32'd5, 1'b0);
        vecs[9]  = mk(6'b000101, 2'b01, 6'b000000, 32'd4, 32'd4, 1'b0,
                      9'b001000001, 7'b0100000, 1'b0, 3'b110, 32'd0, 1'b1);
        vecs[10] = mk(6'b000010, 2'b00, 6'b000000, 32'd1, 32'd2, 1'b0,
                      9'b000000000, 7'b1000000, 1'b0, 3'b010, 32'd3, 1'b0);
        vecs[11] = mk(6'b100011, 2'b10, 6'b100010, 32'd100, 32'd8, 1'b0,
                      9'b110100100, 7'b0010001, 1'b1, 3'b010, 32'd108, 1'b0);
        vecs[12] = mk(6'b101011, 2'b01, 6'b000000, 32'h10, 32'h4, 1'b0,
                      9'b000010100, 7'b0010001, 1'b1, 3'b010, 32'h14, 1'b0);
        vecs[13] = mk(6'b001100, 2'b00, 6'b000000, 32'h0000F0F0, 32'h000000FF, 1'b0,
                      9'b010000100, 7'b0011000, 1'b0, 3'b000, 32'h000000F0, 1'b0);
        vecs[14] = mk(6'b001101, 2'b00, 6'b000000, 32'h0000F0F0, 32'h000000FF, 1'b0,
                      9'b010000100, 7'b0010100, 1'b0, 3'b001, 32'h0000F0FF, 1'b0);
        vecs[15] = mk(6'b001000, 2'b01, 6'b000000, 32'd7, 32'd3, 1'b0,
                      9'b010000100, 7'b0010010, 1'b0, 3'b010, 32'd10, 1'b0);
        vecs[16] = mk(6'b111111, 2'b11, 6'b000000, 32'd2, 32'd2, 1'b0,
                      9'b000000000, 7'b0000000, 1'b0, 3'b010, 32'd4, 1'b0);
        vecs[17] = mk(6'b001000, 2'b00, 6'b000000, 32'd7, 32'd3, 1'b1,
                      9'b010000100, 7'b0010010, 1'b0, 3'b010, 32'd0, 1'b1);
        vecs[18] = mk(6'b000000, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 1'b1,
                      9'b010001010, 7'b0000000, 1'b0, 3'b111, 32'd0, 1'b1);

        // Reset with a load opcode present: delayed flags must stay clear
        reset = 1'b1;
        drive(6'b100011, 2'b01, 6'b000000, 32'd1, 32'd1, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ls_d", {31'd0, ls_d}, 32'd0);
        chk("rst_ls_comb", {31'd0, ls}, 32'd1);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd6);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(6'b000000, 2'b00, 6'b000000, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd2);

        // Table: each vector held across one rising edge, checked after it
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].opcode, vecs[i].alu_op, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].hazard);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ctrl", i), {23'd0, ctrl_out}, {23'd0, vecs[i].ctrl});
            chk($sformatf("v%0d_flags", i), {25'd0, jmp, bne, immediate, andi, ori, addi, ls},
                {25'd0, vecs[i].flags});
            chk($sformatf("v%0d_ls_d", i), {31'd0, ls_d}, {31'd0, vecs[i].ls_d});
            chk($sformatf("v%0d_alu_ctrl", i), {29'd0, alu_ctrl}, {29'd0, vecs[i].alu_ctrl});
            chk($sformatf("v%0d_result", i), result, vecs[i].result);
            chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
        end

        // Load flag latency: ls_d lags ls by exactly one edge
        @(negedge clk);
        drive(6'b000000, 2'b10, 6'b100010, 32'd20, 32'd5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(6'b100011, 2'b10, 6'b100010, 32'd20, 32'd5, 1'b0);
        #1;
        chk("lat_pre_ls_d", {31'd0, ls_d}, 32'd0);
        chk("lat_pre_alu_ctrl", {29'd0, alu_ctrl}, 32'd6);
        chk("lat_pre_result", result, 32'd15);
        @(posedge clk); #1;
        chk("lat_ls_d", {31'd0, ls_d}, 32'd1);
        chk("lat_alu_ctrl", {29'd0, alu_ctrl}, 32'd2);
        chk("lat_result", result, 32'd25);
        @(negedge clk);
        opcode = 6'b000000;
        #1;
        chk("lat_hold_ls_d", {31'd0, ls_d}, 32'd1);
        chk("lat_hold_alu_ctrl", {29'd0, alu_ctrl}, 32'd2);
        chk("lat_hold_ctrl", {23'd0, ctrl_out}, 32'h08A);
        @(posedge clk); #1;
        chk("lat_drop_ls_d", {31'd0, ls_d}, 32'd0);
        chk("lat_drop_alu_ctrl", {29'd0, alu_ctrl}, 32'd6);
        chk("lat_drop_result", result, 32'd15);

        // Reset dominates andi capture at the same edge
        @(negedge clk);
        reset = 1'b1;
        drive(6'b001100, 2'b01, 6'b000000, 32'd9, 32'd4, 1'b0);
        #1;
        chk("rstd_andi_comb", {31'd0, andi}, 32'd1);
        @(posedge clk); #1;
        chk("rstd_alu_ctrl", {29'd0, alu_ctrl}, 32'd6);
        chk("rstd_result", result, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstd_rel_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rstd_rel_result", result, 32'd0);
        chk("rstd_rel_zero", {31'd0, zero}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_decode_exec.md
ALU_DECODE_EXEC -- requirements
Module: alu_decode_exec

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 opcode  in  6  ID-stage instruction bits [31:26].
REQ-004 funct  in  6  EX-stage sign-extended immediate bits [5:0].
REQ-005 alu_op  in  2  EX-stage ALUOp (EXE[1:0]).
REQ-006 data_a, data_b  in  32 each  forwarded ALU operands.
REQ-007 hazard  in  1  load-use stall indicator.
REQ-008 ctrl_out  out  9  control word; [8]=MemtoReg, [7]=RegWrite, [6]=Branch, [5]=MemRead, [4]=MemWrite, [3]=RegDst, [2]=ALUSrc, [1:0]=ALUOp.
REQ-009 jmp, bne, immediate, andi, ori, addi, ls  out  1 each  combinational ID-stage opcode flags.
REQ-010 ls_d  out  1  ls delayed one cycle (EX-stage load/store flag, consumed by forwarding).
REQ-011 alu_ctrl  out  3  ALU operation select.
REQ-012 result  out  32  ALU result; zero  out  1  high when result==0.

Function
REQ-013 Decode, combinational from opcode: 000000 R-type ctrl=0_1_000_1_0_10; 100011 lw ctrl=1_1_010_0_1_00, ls=1, immediate=1; 101011 sw ctrl=0_0_001_0_1_00, ls=1, immediate=1.
REQ-014 000100 beq ctrl=0_0_100_0_0_01; 000101 bne same ctrl plus bne=1; 000010 j ctrl=0, jmp=1.
REQ-015 001000 addi / 001100 andi / 001101 ori: ctrl=0_1_000_0_1_00, immediate=1, plus addi/andi/ori=1 respectively.
REQ-016 Any other opcode: ctrl_out=0, all flags 0.
REQ-017 At most one of jmp, bne, andi, ori, addi asserted; ls only for lw/sw.
REQ-018 andi_d, ori_d, addi_d, ls_d registered from andi, ori, addi, ls every cycle (one-cycle latency, no enable).
REQ-019 alu_ctrl priority: andi_d->000; else ori_d->001; else addi_d or ls_d->010; else by alu_op.
REQ-020 alu_op 00->010, 01->110, 11->010, 10->by funct.
REQ-021 funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-022 ALU codes: 000 AND, 001 OR, 010 ADD (mod 2^32, no overflow flag), 110 SUB (a-b mod 2^32), 111 SLT signed (result 1 or 0); 011/100/101 -> result 0.
REQ-023 hazard=1 forces result=0 (zero=1) regardless of operands/alu_ctrl; hazard=0 normal.
REQ-024 ALU, ALU-control selection and decode purely combinational; only the four delayed flags are state.

Reset
REQ-025 reset high at a rising edge clears andi_d, ori_d, addi_d, ls_d to 0; reset dominates flag capture that cycle.
REQ-026 During/after reset, outputs follow combinational inputs; with alu_op=00 after reset, alu_ctrl=010.

Structure
REQ-027 Shared package: opcode constants, funct constants, 3-bit ALU op encodings, control-word bit indices.
REQ-028 One sub-module natural: alu_core (32-bit combinational datapath: operands, alu_ctrl, hazard -> result, zero); decode and ALU-control selection stay in top.

Verification
REQ-029 opcode=100011 -> ctrl_out=9'b110100100, ls=1, immediate=1; next cycle ls_d=1, alu_ctrl=010 for any alu_op/funct.
REQ-030 alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> alu_ctrl=111, result=1; a=1, b=0xFFFFFFFF -> result=0.
REQ-031 alu_op=10, funct=100010, a=5, b=5 -> alu_ctrl=110, result=0, zero=1; a=0, b=1 -> result=0xFFFFFFFF.
REQ-032 opcode=001100 one cycle, then alu_op=00 -> alu_ctrl=000, a=0xF0F0, b=0x00FF -> result=0x00F0; opcode=001101 path -> 001, result=0xF0FF.
REQ-033 a=0xFFFFFFFF, b=1, ADD -> result=0 (wrap); same with hazard=1 and a=7, b=3 -> result=0.
REQ-034 opcode=111111 -> ctrl_out=0, all flags 0; assert andi then reset at next edge -> andi_d=0, alu_ctrl follows alu_op.
